main_mem_resp: RTL and testbench

//  Unified main-memory responder: the memory side of the cache-controller miss protocol.
//  - Accepts single-cycle read/write line strobes and returns 64-bit lines after a fixed latency.
//  - Signals completion with a one-cycle rdy pulse.
//  - Sits below the I/D cache controller; serves fills and dirty write-backs for both caches.

---
 rtl/main_mem_resp.sv | 137 +++++++++++++
 tb/tb_main_mem_resp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_resp.sv
// Main-memory responder for the I/D cache miss protocol: fixed-latency line reads and writes.
// Optional protocol-error checking is enabled by defining MAIN_MEM_ERR_CHK_EN.
module main_mem_resp #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rdy_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        unique case (state_q)
            StIdle: begin
                if (we_i || re_i) begin
                    addr_d  = addr_i;
                    op_wr_d = we_i;
                    if (we_i) begin
                        wdata_d = wr_data_i;
                    end
                    cnt_d   = CntInit;
                    state_d = (LAT == 1) ? StDone : StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // With LAT=1 the read completes straight from IDLE, so the address comes from the port.
    always_comb begin
        rd_addr = (state_q == StIdle) ? addr_i : addr_q;
        rd_load = (state_d == StDone) && (state_q != StDone) &&
                  ((state_q == StIdle) ? !we_i : !op_wr_q);
        mem_we  = (state_q == StDone) && op_wr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            if (rd_load) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    // Storage deliberately has no reset; an aborted write never reaches DONE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rdy_o     = (state_q == StDone);
    assign busy_o    = (state_q == StBusy);

`ifdef MAIN_MEM_ERR_CHK_EN
    logic err_q;
    logic err_set;

    assign err_set = (re_i && we_i) || ((re_i || we_i) && (state_q != StIdle));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && err_set) begin
            $display("%0t main_mem_resp: protocol error, addr=0x%0h", $time, addr_i);
        end
    end
`endif

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_main_mem_resp.sv
// Randomized self-checking bench for main_mem_resp against an associative-array memory model.
module tb_main_mem_resp;

    localparam int AW  = 14;
    localparam int DW  = 64;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          re, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rdy, busy, err;

    main_mem_resp #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .re_i     (re),
        .we_i     (we),
        .addr_i   (addr),
        .wr_data_i(wr_data),
        .rd_data_o(rd_data),
        .rdy_o    (rdy),
        .busy_o   (busy),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int unsigned   pass_cnt = 0;
    int unsigned   chk_cnt  = 0;
    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] last_rd;
    logic          err_exp;
    int            written_q[$];

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom};
    endfunction

    // One request from an IDLE cycle; returns in the IDLE cycle after rdy.
    task automatic run_req(input string nm, input logic w, input logic r, input int a,
                           input logic [DW-1:0] d, input bit noise);
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_rdd;
        bit            strobed;
        exp_rd = '0;
        if (!w) exp_rd = model_mem[a];
        we = w; re = r; addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
`ifdef MAIN_MEM_ERR_CHK_EN
        if (w && r) err_exp = 1'b1;
`endif
        for (int k = 1; k <= LAT; k++) begin
            strobed = 1'b0;
            if (noise) begin
                re = 1'($urandom); we = 1'($urandom);
                addr = AW'($urandom); wr_data = rand_line();
                strobed = re | we;
            end else begin
                re = 1'b0; we = 1'b0;
            end
            @(negedge clk);
            exp_rdd = (k == LAT && !w) ? exp_rd : last_rd;
            if (rdy !== (k == LAT)) $display("FAIL %s rdy k=%0d: got %b want %b", nm, k, rdy, k == LAT);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== (k < LAT)) $display("FAIL %s busy k=%0d: got %b want %b", nm, k, busy, k < LAT);
            else pass_cnt++;
            chk_cnt++;
            if (rd_data !== exp_rdd) $display("FAIL %s rd_data k=%0d: got %h want %h", nm, k, rd_data, exp_rdd);
            else pass_cnt++;
            chk_cnt++;
            if (err !== err_exp) $display("FAIL %s err k=%0d: got %b want %b", nm, k, err, err_exp);
            else pass_cnt++;
            chk_cnt++;
`ifdef MAIN_MEM_ERR_CHK_EN
            if (strobed) err_exp = 1'b1;
`endif
            @(posedge clk); #1;
        end
        re = 1'b0; we = 1'b0;
        if (rdy !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s idle after rdy: got rdy=%b busy=%b want 0 0", nm, rdy, busy);
        else pass_cnt++;
        chk_cnt++;
        if (w) begin
            model_mem[a] = d;
            written_q.push_back(a);
        end else begin
            last_rd = exp_rd;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        last_rd = '0;
        err_exp = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        if (rd_data !== '0) $display("FAIL reset rd_data: got %h want 0", rd_data);
        else pass_cnt++;
        chk_cnt++;
        if (rdy !== 1'b0) $display("FAIL reset rdy: got %b want 0", rdy);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err);
        else pass_cnt++;
        chk_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_read_after_reset();
        run_req("preload5", 1'b1, 1'b0, 'h0005, rand_line(), 1'b0);
        apply_reset();
        run_req("read5", 1'b0, 1'b1, 'h0005, '0, 1'b0);
    endtask

    task automatic test_write_read();
        run_req("wr1234", 1'b1, 1'b0, 'h1234, 64'hDEADBEEF_01234567, 1'b0);
        run_req("rd1234", 1'b0, 1'b1, 'h1234, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_req("pre0B01", 1'b1, 1'b0, 'h0B01, rand_line(), 1'b0);
        run_req("pre0A01", 1'b1, 1'b0, 'h0A01, rand_line(), 1'b0);
        run_req("wb0A01", 1'b1, 1'b0, 'h0A01, rand_line(), 1'b0);
        run_req("fill0B01", 1'b0, 1'b1, 'h0B01, '0, 1'b0);
        run_req("rd0A01", 1'b0, 1'b1, 'h0A01, '0, 1'b0);
    endtask

    task automatic test_collision();
        run_req("coll3", 1'b1, 1'b1, 'h0003, 64'h1, 1'b0);
        run_req("rd3_noise", 1'b0, 1'b1, 'h0003, '0, 1'b1);
    endtask

    task automatic test_reset_midop();
        for (int n = 0; n < 3; n++) begin
            int            a;
            int            k;
            logic [DW-1:0] oldv;
            a = 'h0100 + n;
            oldv = rand_line();
            run_req("midop_pre", 1'b1, 1'b0, a, oldv, 1'b0);
            k = (n == 0) ? 2 : int'($urandom_range(1, LAT));
            we = 1'b1; addr = AW'(a); wr_data = ~oldv;
            @(posedge clk); #1;
            we = 1'b0;
            for (int j = 1; j < k; j++) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            #1;
            if (rdy !== 1'b0 || busy !== 1'b0 || rd_data !== '0)
                $display("FAIL midop reset outputs k=%0d: got rdy=%b busy=%b rd=%h want 0", k, rdy, busy, rd_data);
            else pass_cnt++;
            chk_cnt++;
            repeat (2) begin
                @(negedge clk);
                if (rdy !== 1'b0) $display("FAIL midop rdy in reset: got %b want 0", rdy);
                else pass_cnt++;
                chk_cnt++;
            end
            @(posedge clk); #1 rst_n = 1'b1;
            last_rd = '0;
            err_exp = 1'b0;
            repeat (LAT + 1) begin
                @(negedge clk);
                if (rdy !== 1'b0) $display("FAIL midop rdy after abort: got %b want 0", rdy);
                else pass_cnt++;
                chk_cnt++;
            end
            @(posedge clk); #1;
            run_req("midop_rd", 1'b0, 1'b1, a, '0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int  sel;
            bit  noise;
            sel   = int'($urandom_range(0, 9));
            noise = ($urandom_range(0, 3) == 0);
            if (sel < 4 || written_q.size() == 0)
                run_req("rnd_wr", 1'b1, 1'b0, int'($urandom_range(0, 2**AW - 1)), rand_line(), noise);
            else if (sel < 9)
                run_req("rnd_rd", 1'b0, 1'b1, written_q[$urandom_range(0, written_q.size() - 1)], '0, noise);
            else
                run_req("rnd_coll", 1'b1, 1'b1, int'($urandom_range(0, 2**AW - 1)), rand_line(), noise);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; addr = '0; wr_data = '0;
        last_rd = '0;
        err_exp = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
